// File: rtl/wb_sequencer.sv
// Write-back sequencer: accepts one register-file write request, waits for the
// selected result source to become valid, then issues a single-cycle write.
module wb_sequencer #(
  parameter int WAIT_MAX = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [3:0] wb_src,
  input  logic [4:0] wb_dst,
  input  logic       multdiv_busy,
  input  logic       shift_busy,
  output logic [3:0] mux_dataSource_control,
  output logic       reg_write,
  output logic [4:0] write_reg,
  output logic       wb_ack,
  output logic       wb_err,
  output logic       wb_busy
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    src_r, src_s;
  logic [4:0]    dst_r, dst_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          rw_r, ack_r, err_r, busy_r;
  logic          rw_s, ack_s, err_s, busy_s;

  // Only the HI/LO and shift-register sources can be not-yet-valid.
  function automatic logic src_pending(input logic [3:0] src,
                                       input logic       md_busy,
                                       input logic       sh_busy);
    logic pend;
    case (src)
      4'd2, 4'd3: pend = md_busy;
      4'd4:       pend = sh_busy;
      default:    pend = 1'b0;
    endcase
    return pend;
  endfunction

  // Next-state, latch and wait-counter logic.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (wb_req) begin
          src_s = wb_src;
          dst_s = wb_dst;
          cnt_s = '0;
          if (wb_src >= 4'd10) begin
            state_s = S_ERR;
          end else if (src_pending(wb_src, multdiv_busy, shift_busy)) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_WRITE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!src_pending(src_r, multdiv_busy, shift_busy)) begin
          state_s = S_WRITE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = S_ERR;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_WRITE: state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they come straight off flops.
  always_comb begin
    ack_s  = (state_s == S_WRITE);
    rw_s   = (state_s == S_WRITE) && (dst_s != 5'd0);
    err_s  = (state_s == S_ERR);
    busy_s = (state_s != S_IDLE);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      src_r   <= 4'd0;
      dst_r   <= 5'd0;
      cnt_r   <= '0;
      rw_r    <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      cnt_r   <= cnt_s;
      rw_r    <= rw_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
    end
  end

  assign mux_dataSource_control = src_r;
  assign write_reg              = dst_r;
  assign reg_write              = rw_r;
  assign wb_ack                 = ack_r;
  assign wb_err                 = err_r;
  assign wb_busy                = busy_r;

  wb_sequencer_checker u_chk (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err)
  );

endmodule

// Protocol invariants of the sequencer outputs.
module wb_sequencer_checker (
  input logic clk,
  input logic reset,
  input logic reg_write,
  input logic wb_ack,
  input logic wb_err
);

  a_ack_err_excl: assert property (@(posedge clk) disable iff (!reset)
    !(wb_ack && wb_err));

  a_write_only_on_ack: assert property (@(posedge clk) disable iff (!reset)
    reg_write |-> wb_ack);

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multicycle MIPS datapath: accepts one register-file write request at a time from the main control unit, waits until the selected result source is valid, then drives the register-file data-source mux select, `reg_write` and `write_reg` for exactly one cycle. It sits between the control FSM and the register-file data-source mux, and owns all write-back timing for multi-cycle results (HI/LO from mult/div, shift register).

## Interface
- `WAIT_MAX`, default 64: maximum cycles spent in WAIT before a timeout error; legal range 2..255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_req`  in  1  write-back request; held by requester until `wb_ack` or `wb_err` is seen.
- `wb_src`  in  4  source code: 0 ALUOut, 1 SLS, 2 LO, 3 HI, 4 shift reg, 5 LT, 6 sign-extend, 7 shift-left-16, 8 reg A, 9 reg B; 10..15 illegal.
- `wb_dst`  in  5  destination register number.
- `multdiv_busy`  in  1  high while mult/div unit is computing; HI/LO valid when low.
- `shift_busy`  in  1  high while shift register is operating; its output valid when low.
- `mux_dataSource_control`  out  4  select to the data-source mux.
- `reg_write`  out  1  register-file write enable.
- `write_reg`  out  5  register-file write address.
- `wb_ack`  out  1  one-cycle pulse: write-back performed (or suppressed for `$zero`).
- `wb_err`  out  1  one-cycle pulse: request rejected (illegal source or timeout).
- `wb_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, WRITE, ERR; all outputs Moore (registered state/latched fields only).
- IDLE: `wb_req` sampled only here. On `wb_req`=1: latch `wb_src`, `wb_dst`; clear wait counter.
  - `wb_src` >= 10 -> ERR.
  - source 2/3 with `multdiv_busy`=1, or source 4 with `shift_busy`=1 -> WAIT.
  - otherwise -> WRITE.
- WAIT: relevant busy low -> WRITE. Busy high and count < `WAIT_MAX`-1 -> count+1, stay. Busy high and count = `WAIT_MAX`-1 -> ERR.
- WRITE: `reg_write` = (latched dst != 0); `write_reg` = latched dst; `wb_ack`=1; -> IDLE.
- ERR: `wb_err`=1; `reg_write`=0; -> IDLE.
- `mux_dataSource_control` = latched src at all times after a latch (held stable through WAIT, WRITE and following IDLE); in ERR from illegal src it still shows the latched code but `reg_write` is 0.
- Destination 0: full sequence runs, `wb_ack` pulses, `reg_write` stays 0.
- Counter width: ceil(log2(`WAIT_MAX`)) bits; never wraps (saturates into ERR).
- Reset (any state, including mid-WAIT/WRITE): asynchronously to IDLE; pending write dropped, no write performed.

## Timing
- Reset values: `mux_dataSource_control`=0, `reg_write`=0, `write_reg`=0, `wb_ack`=0, `wb_err`=0, `wb_busy`=0, counter=0.
- Ready source: `wb_req` seen in IDLE cycle N -> WRITE in cycle N+1 (`reg_write`, `wb_ack` high); register file captures at end of N+1. Latency 1 cycle.
- Waiting source: busy falls in cycle M during WAIT -> WRITE in M+1.
- Timeout: `wb_err` high exactly `WAIT_MAX`+1 cycles after the accepting IDLE cycle.
- Handshake: requester deasserts `wb_req` on the edge ending the `wb_ack`/`wb_err` cycle; the following IDLE cycle sees `wb_req`=0. Earliest back-to-back accept: 2 cycles per request. `wb_req` outside IDLE ignored; `wb_src`/`wb_dst` changes after acceptance ignored.
- `wb_ack` and `wb_err` never high in the same cycle; `reg_write` high only in WRITE.

## Test plan
- Reset, then `wb_req`, src=0, dst=8 -> next cycle `reg_write`=1, `write_reg`=8, `mux_dataSource_control`=0, `wb_ack`=1; following cycle all pulses 0, `wb_busy`=0.
- src=3, dst=9 with `multdiv_busy` high for 33 cycles after request -> 33 WAIT cycles, WRITE on cycle 34 with control=3, `reg_write`=1.
- `WAIT_MAX`=4, src=4, `shift_busy` stuck high -> `wb_err`=1 on cycle 5 after accept, `reg_write` never asserts, returns IDLE.
- src=12 -> `wb_err` next cycle, no write; src=5, dst=0 -> `wb_ack`=1 with `reg_write`=0.
- src=2 in WAIT, `reset` low for one cycle mid-WAIT -> all outputs 0 immediately, no `reg_write` after release; new request then completes normally.
